// File: rtl/vga_1280x1024_timing.sv
// Raster timing generator for 1280x1024 @ 60 Hz from a 108 MHz pixel clock.
// Sync outputs are decoded from next-state counters so they align with x_loc/y_loc.
module vga_1280x1024_timing #(
  parameter int H_VISIBLE = 1280,
  parameter int H_FRONT   = 48,
  parameter int H_SYNC    = 112,
  parameter int H_BACK    = 248,
  parameter int V_VISIBLE = 1024,
  parameter int V_FRONT   = 1,
  parameter int V_SYNC    = 3,
  parameter int V_BACK    = 38
) (
  input  logic        clk_108Mhz,
  input  logic        reset,
  output logic        h_sync,
  output logic        v_sync,
  output logic [10:0] x_loc,
  output logic [10:0] y_loc
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_SYNC_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SYNC_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_SYNC_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] V_SYNC_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;

  always_comb begin
    x_d = x_q + 11'd1;
    y_d = y_q;
    if (x_q == H_LAST) begin
      x_d = '0;
      y_d = (y_q == V_LAST) ? '0 : y_q + 11'd1;
    end
    // Decode from next-state values so the registered syncs match the registered position.
    hs_d = (x_d >= H_SYNC_START) && (x_d < H_SYNC_END);
    vs_d = (y_d >= V_SYNC_START) && (y_d < V_SYNC_END);
  end

  always_ff @(posedge clk_108Mhz) begin
    if (reset) begin
      x_q  <= '0;
      y_q  <= '0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
    end
  end

  assign x_loc  = x_q;
  assign y_loc  = y_q;
  assign h_sync = hs_q;
  assign v_sync = vs_q;

endmodule

// File: tb/tb_vga_1280x1024_timing.sv
// Bench for vga_1280x1024_timing: full-size instance for line timing, a scaled
// instance for frame-level behaviour, both checked against an arithmetic raster model.
module tb_vga_1280x1024_timing;

  localparam int BHV = 1280, BHF = 48, BHS = 112, BHB = 248;
  localparam int BVV = 1024, BVF = 1,  BVS = 3,   BVB = 38;
  localparam int SHV = 20,   SHF = 2,  SHS = 4,   SHB = 3;
  localparam int SVV = 12,   SVF = 1,  SVS = 3,   SVB = 2;
  localparam int SHT = SHV + SHF + SHS + SHB;
  localparam int SVT = SVV + SVF + SVS + SVB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hs_b, vs_b, hs_s, vs_s;
  logic [10:0] x_b, y_b, x_s, y_s;

  int pass_cnt = 0;
  int total_cnt = 0;
  int n = 0;

  always #5 clk = ~clk;

  vga_1280x1024_timing u_big (
    .clk_108Mhz(clk), .reset(reset),
    .h_sync(hs_b), .v_sync(vs_b), .x_loc(x_b), .y_loc(y_b)
  );

  vga_1280x1024_timing #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) u_small (
    .clk_108Mhz(clk), .reset(reset),
    .h_sync(hs_s), .v_sync(vs_s), .x_loc(x_s), .y_loc(y_s)
  );

  wire [23:0] obs_b = {hs_b, vs_b, x_b, y_b};
  wire [23:0] obs_s = {hs_s, vs_s, x_s, y_s};

  // Position after n free-running edges since reset: {h_sync, v_sync, x, y}.
  function automatic logic [23:0] model(input int cnt, input int hv, input int hf,
                                        input int hs, input int hb, input int vv,
                                        input int vf, input int vs, input int vb);
    int ht = hv + hf + hs + hb;
    int vt = vv + vf + vs + vb;
    int x  = cnt % ht;
    int y  = (cnt / ht) % vt;
    logic h = (x >= hv + hf) && (x < hv + hf + hs);
    logic v = (y >= vv + vf) && (y < vv + vf + vs);
    return {h, v, 11'(x), 11'(y)};
  endfunction

  function automatic logic [23:0] mb(input int cnt);
    return model(cnt, BHV, BHF, BHS, BHB, BVV, BVF, BVS, BVB);
  endfunction

  function automatic logic [23:0] ms(input int cnt);
    return model(cnt, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB);
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) n = 0;
    else n++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    total_cnt++;
    if (obs_b !== 24'h0) $display("FAIL reset_big got %h want %h", obs_b, 24'h0);
    else pass_cnt++;
    total_cnt++;
    if (obs_s !== 24'h0) $display("FAIL reset_small got %h want %h", obs_s, 24'h0);
    else pass_cnt++;
    reset = 1'b0;
    tick(); tick(); tick();
    total_cnt++;
    if (obs_b !== {1'b0, 1'b0, 11'd3, 11'd0})
      $display("FAIL release3_big got %h want %h", obs_b, {1'b0, 1'b0, 11'd3, 11'd0});
    else pass_cnt++;
  endtask

  task automatic test_line();
    int hs_high = 0, hs_rise = 0;
    logic prev = 1'b0;
    do_reset();
    for (int i = 0; i < 1688; i++) begin
      tick();
      total_cnt++;
      if (obs_b !== mb(n)) $display("FAIL line_big n=%0d got %h want %h", n, obs_b, mb(n));
      else pass_cnt++;
      if (hs_b) hs_high++;
      if (hs_b && !prev) hs_rise++;
      prev = hs_b;
    end
    total_cnt++;
    if ({x_b, y_b} !== {11'd0, 11'd1})
      $display("FAIL line_end got x=%0d y=%0d want x=0 y=1", x_b, y_b);
    else pass_cnt++;
    total_cnt++;
    if (hs_high !== 112) $display("FAIL line_hs_width got %0d want 112", hs_high);
    else pass_cnt++;
    total_cnt++;
    if (hs_rise !== 1) $display("FAIL line_hs_pulses got %0d want 1", hs_rise);
    else pass_cnt++;
  endtask

  task automatic test_frame();
    int hs_rise = 0, vs_high = 0, vs_rise = 0;
    logic ph = 1'b0, pv = 1'b0;
    do_reset();
    for (int i = 0; i < SHT * SVT; i++) begin
      tick();
      total_cnt++;
      if (obs_s !== ms(n)) $display("FAIL frame_small n=%0d got %h want %h", n, obs_s, ms(n));
      else pass_cnt++;
      if (hs_s && !ph) hs_rise++;
      if (vs_s && !pv) vs_rise++;
      if (vs_s) vs_high++;
      ph = hs_s;
      pv = vs_s;
    end
    total_cnt++;
    if ({x_s, y_s} !== 22'h0) $display("FAIL frame_end got x=%0d y=%0d want 0 0", x_s, y_s);
    else pass_cnt++;
    total_cnt++;
    if (hs_rise !== SVT) $display("FAIL frame_hs_pulses got %0d want %0d", hs_rise, SVT);
    else pass_cnt++;
    total_cnt++;
    if (vs_high !== SVS * SHT) $display("FAIL frame_vs_width got %0d want %0d", vs_high, SVS * SHT);
    else pass_cnt++;
    total_cnt++;
    if (vs_rise !== 1) $display("FAIL frame_vs_pulses got %0d want 1", vs_rise);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    do_reset();
    while (n < SVV * SHT + SHT - 1) tick();
    total_cnt++;
    if ({x_s, y_s} !== {11'(SHT - 1), 11'(SVV)})
      $display("FAIL wrap_pre_vs got x=%0d y=%0d want x=%0d y=%0d", x_s, y_s, SHT - 1, SVV);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (obs_s !== {1'b0, 1'b1, 11'd0, 11'(SVV + 1)})
      $display("FAIL wrap_vs_rise got %h want %h", obs_s, {1'b0, 1'b1, 11'd0, 11'(SVV + 1)});
    else pass_cnt++;
    while (n < SVT * SHT - 1) tick();
    total_cnt++;
    if ({x_s, y_s} !== {11'(SHT - 1), 11'(SVT - 1)})
      $display("FAIL wrap_pre_frame got x=%0d y=%0d", x_s, y_s);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (obs_s !== 24'h0) $display("FAIL wrap_frame got %h want %h", obs_s, 24'h0);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    while (n < 14 * SHT + 24) tick();
    total_cnt++;
    if (obs_s !== {1'b1, 1'b1, 11'd24, 11'd14})
      $display("FAIL mid_pre got %h want %h", obs_s, {1'b1, 1'b1, 11'd24, 11'd14});
    else pass_cnt++;
    reset = 1'b1;
    tick();
    total_cnt++;
    if (obs_s !== 24'h0) $display("FAIL mid_reset_small got %h want 0", obs_s);
    else pass_cnt++;
    total_cnt++;
    if (obs_b !== 24'h0) $display("FAIL mid_reset_big got %h want 0", obs_b);
    else pass_cnt++;
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      total_cnt++;
      if (obs_s !== ms(n)) $display("FAIL mid_restart n=%0d got %h want %h", n, obs_s, ms(n));
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_hold();
    do_reset();
    repeat ($urandom_range(30, 400)) tick();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total_cnt++;
      if ({obs_b, obs_s} !== 48'h0)
        $display("FAIL hold_reset cyc=%0d got big=%h small=%h want 0", i, obs_b, obs_s);
      else pass_cnt++;
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int len = $urandom_range(50, 2500);
      for (int i = 0; i < len; i++) begin
        tick();
        total_cnt++;
        if (obs_b !== mb(n)) $display("FAIL rand_big n=%0d got %h want %h", n, obs_b, mb(n));
        else pass_cnt++;
        total_cnt++;
        if (obs_s !== ms(n)) $display("FAIL rand_small n=%0d got %h want %h", n, obs_s, ms(n));
        else pass_cnt++;
      end
      reset = 1'b1;
      repeat ($urandom_range(1, 3)) tick();
      reset = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_wrap();
    test_mid_reset();
    test_reset_hold();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
